ucounter_ctrl: RTL and testbench

- Timer sequencer that drives the control side of a 16-bit chained up/down counter: preload value, load strobe, direction, wrap/stop and the carry_in count-enable tick.
- Consumes the counter's overflow and current value.
- Turns a host start/stop command plus period/prescale settings into one-shot or periodic expiry events (done pulse, sticky irq).
- Sits between host registers and the counter instance; all counter-side ports are driven from here.

---
 rtl/ucounter_pkg.sv | 16 +
 rtl/ucounter_ctrl_if.sv | 36 +++
 rtl/ucounter_prescaler.sv | 27 ++
 rtl/ucounter_ctrl.sv | 128 ++++++++++++
 tb/tb_ucounter_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucounter_pkg.sv
// Shared types and constants for the counter timer sequencer.
package ucounter_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_PS_W  = 8;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;
    localparam logic [15:0] CNT_MIN = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/ucounter_ctrl_if.sv
// Control/status bundle between the timer sequencer (master) and the chained counter (slave).
interface ucounter_ctrl_if
    import ucounter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             cnt_load_n;
    logic [CNT_W-1:0] cnt_preld_val;
    logic             cnt_updown_n;
    logic             cnt_wrapstop_n;
    logic             cnt_carry_in;
    logic             cnt_overflow;
    logic [CNT_W-1:0] cnt_value;

    modport master (
        output cnt_load_n,
        output cnt_preld_val,
        output cnt_updown_n,
        output cnt_wrapstop_n,
        output cnt_carry_in,
        input  cnt_overflow,
        input  cnt_value
    );

    modport slave (
        input  cnt_load_n,
        input  cnt_preld_val,
        input  cnt_updown_n,
        input  cnt_wrapstop_n,
        input  cnt_carry_in,
        output cnt_overflow,
        output cnt_value
    );

endinterface

// File: rtl/ucounter_prescaler.sv
// Clock divider for the counter: emits one tick every (limit+1) enabled clocks.
module ucounter_prescaler #(
    parameter int PS_W = 8
) (
    input  logic            clk,
    input  logic            _areset,
    input  logic            clear,
    input  logic            enable,
    input  logic [PS_W-1:0] limit,
    output logic            tick
);

    logic [PS_W-1:0] count;

    assign tick = enable && (count == limit);

    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + PS_W'(1);
        end
    end

endmodule

// File: rtl/ucounter_ctrl.sv
// Timer sequencer: turns host start/stop and period/prescale into counter control and expiry events.
// Optional feature UCTRL_CAPTURE_EN adds the capture input and cap_value register.
module ucounter_ctrl
    import ucounter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PS_W  = DEF_PS_W
) (
    input  logic             clk,
    input  logic             _areset,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             dir_down,
    input  logic [CNT_W-1:0] period,
    input  logic [PS_W-1:0]  prescale,
    input  logic             irq_clr,
    ucounter_ctrl_if.master  cnt,
    output logic             busy,
    output logic             done,
    output logic             irq
`ifdef UCTRL_CAPTURE_EN
   ,input  logic             capture,
    output logic [CNT_W-1:0] cap_value
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] period_s;
    logic [PS_W-1:0]  prescale_s;
    logic             periodic_s;
    logic             dir_down_s;
    logic             expire;
    logic             reload;
    logic             ps_tick;

    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Host settings only take effect through an accepted start.
    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            period_s   <= '0;
            prescale_s <= '0;
            periodic_s <= 1'b0;
            dir_down_s <= 1'b0;
        end else if (start && !stop) begin
            period_s   <= period;
            prescale_s <= prescale;
            periodic_s <= periodic;
            dir_down_s <= dir_down;
        end
    end

    always_comb begin
        state_nxt = state;
        expire    = 1'b0;
        reload    = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = LOAD;
                LOAD: state_nxt = start ? LOAD : RUN;
                RUN: begin
                    expire = cnt.cnt_overflow;
                    reload = cnt.cnt_overflow && periodic_s;
                    if (start) begin
                        state_nxt = LOAD;
                    end else if (cnt.cnt_overflow && !periodic_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    ucounter_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk     (clk),
        ._areset (_areset),
        .clear   (state != RUN),
        .enable  ((state == RUN) && !stop),
        .limit   (prescale_s),
        .tick    (ps_tick)
    );

    // Outside a run the counter-side controls rest at neutral values.
    assign cnt.cnt_carry_in   = ps_tick;
    assign cnt.cnt_load_n     = !((state == LOAD) || reload);
    assign cnt.cnt_preld_val  = (state == IDLE) ? '0 : (dir_down_s ? period_s : ~period_s);
    assign cnt.cnt_updown_n   = !dir_down_s;
    assign cnt.cnt_wrapstop_n = periodic_s || (state == IDLE);
    assign busy               = (state == LOAD) || (state == RUN);

    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            done <= 1'b0;
            irq  <= 1'b0;
        end else begin
            done <= expire;
            if (expire) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

`ifdef UCTRL_CAPTURE_EN
    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            cap_value <= '0;
        end else if (expire || (capture && busy)) begin
            cap_value <= cnt.cnt_value;
        end
    end
`endif

endmodule

// File: tb/tb_ucounter_ctrl.sv
// Self-checking bench for ucounter_ctrl with a behavioural chained-counter model and a done-time scoreboard.
module tb_ucounter_ctrl;
    import ucounter_pkg::*;

    localparam int CNT_W = 16;
    localparam int PS_W  = 8;

    logic             clk = 1'b0;
    logic             _areset;
    logic             start, stop, periodic, dir_down, irq_clr;
    logic [CNT_W-1:0] period;
    logic [PS_W-1:0]  prescale;
    logic             busy, done, irq;
`ifdef UCTRL_CAPTURE_EN
    logic             capture;
    logic [CNT_W-1:0] cap_value;
`endif

    logic             ovf_force;
    logic             val_force_en;
    logic [CNT_W-1:0] val_force;
    logic [CNT_W-1:0] model_val;
    logic             at_term;

    int cyc = 0;
    int vec_count = 0;
    int miss_count = 0;
    int exp_q[$];

    ucounter_ctrl_if #(.CNT_W(CNT_W)) cnt ();

    ucounter_ctrl #(
        .CNT_W (CNT_W),
        .PS_W  (PS_W)
    ) dut (
        .clk      (clk),
        ._areset  (_areset),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .dir_down (dir_down),
        .period   (period),
        .prescale (prescale),
        .irq_clr  (irq_clr),
        .cnt      (cnt),
        .busy     (busy),
        .done     (done),
        .irq      (irq)
`ifdef UCTRL_CAPTURE_EN
       ,.capture  (capture),
        .cap_value(cap_value)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Chained counter model; the force inputs let the bench inject overflow and value events.
    assign at_term = cnt.cnt_updown_n ? (model_val == CNT_MAX) : (model_val == CNT_MIN);
    assign cnt.cnt_overflow = (cnt.cnt_carry_in && at_term) || ovf_force;
    assign cnt.cnt_value    = val_force_en ? val_force : model_val;

    always @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            model_val <= '0;
        end else if (!cnt.cnt_load_n) begin
            model_val <= cnt.cnt_preld_val;
        end else if (cnt.cnt_carry_in) begin
            if (!at_term) begin
                model_val <= cnt.cnt_updown_n ? model_val + 16'd1 : model_val - 16'd1;
            end else if (cnt.cnt_wrapstop_n) begin
                model_val <= cnt.cnt_updown_n ? CNT_MIN : CNT_MAX;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each done must appear exactly at the cycle queued when its run was started.
    always @(negedge clk) begin
        if (_areset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("done_unexpected", done, 0);
            end else begin
                check_output("done_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input logic per, input logic dn, input int p, input int s, input int n_exp);
        int n;
        periodic = per;
        dir_down = dn;
        period   = CNT_W'(p);
        prescale = PS_W'(s);
        start    = 1'b1;
        n = (p + 1) * (s + 1);
        for (int k = 0; k < n_exp; k++) exp_q.push_back(cyc + 2 + n + k * n);
        step(1);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check_output({pfx, "_load_n"},   cnt.cnt_load_n, 1);
        check_output({pfx, "_preld"},    cnt.cnt_preld_val, 0);
        check_output({pfx, "_updown_n"}, cnt.cnt_updown_n, 1);
        check_output({pfx, "_wrap_n"},   cnt.cnt_wrapstop_n, 1);
        check_output({pfx, "_carry"},    cnt.cnt_carry_in, 0);
        check_output({pfx, "_busy"},     busy, 0);
        check_output({pfx, "_done"},     done, 0);
        check_output({pfx, "_irq"},      irq, 0);
`ifdef UCTRL_CAPTURE_EN
        check_output({pfx, "_cap"},      cap_value, 0);
`endif
    endtask

    task automatic pulse_irq_clr();
        irq_clr = 1'b1;
        step(1);
        irq_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        _areset = 1'b0;
        {start, stop, periodic, dir_down, irq_clr} = '0;
        period = '0;
        prescale = '0;
        {ovf_force, val_force_en} = '0;
        val_force = '0;
`ifdef UCTRL_CAPTURE_EN
        capture = 1'b0;
`endif
        #12;
        check_reset_values("por");
        _areset = 1'b1;
        step(2);

        // One-shot up: preload ~3, tick every 2nd clock, done 9 clocks after LOAD.
        apply_stimulus(1'b0, 1'b0, 3, 1, 1);
        check_output("os_load_n", cnt.cnt_load_n, 0);
        check_output("os_preld", cnt.cnt_preld_val, 16'hFFFC);
        check_output("os_updown_n", cnt.cnt_updown_n, 1);
        check_output("os_wrap_n", cnt.cnt_wrapstop_n, 0);
        check_output("os_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check_output("os_carry", cnt.cnt_carry_in, (i % 2 == 1) ? 1 : 0);
            check_output("os_run_load_n", cnt.cnt_load_n, 1);
        end
        step(1);
        check_output("os_end_busy", busy, 0);
        check_output("os_end_irq", irq, 1);
        check_output("os_end_carry", cnt.cnt_carry_in, 0);
        step(1);
        check_output("os_done_seen", exp_q.size(), 0);
        pulse_irq_clr();
        check_output("irq_cleared", irq, 0);

        // Periodic down, period 2, prescale 0; later host edits must not disturb the run.
        apply_stimulus(1'b1, 1'b1, 2, 0, 4);
        check_output("per_preld", cnt.cnt_preld_val, 2);
        check_output("per_updown_n", cnt.cnt_updown_n, 0);
        check_output("per_wrap_n", cnt.cnt_wrapstop_n, 1);
        period = 16'd9;
        prescale = 8'd3;
        periodic = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check_output("per_reload_strobe", cnt.cnt_load_n, !cnt.cnt_overflow);
            check_output("per_carry_every", cnt.cnt_carry_in, 1);
            check_output("per_no_ffff", cnt.cnt_value == 16'hFFFF, 0);
        end
        step(2);
        check_output("per_done_seen", exp_q.size(), 0);
        check_output("per_busy", busy, 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_output("per_stop_busy", busy, 0);
        pulse_irq_clr();

        // start together with stop while running: stop wins.
        apply_stimulus(1'b0, 1'b0, 50, 0, 0);
        step(3);
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        check_output("ss_busy", busy, 0);
        check_output("ss_load_n", cnt.cnt_load_n, 1);
        step(3);
        check_output("ss_still_idle", busy, 0);

        // stop coincident with an overflow discards the expiry.
        apply_stimulus(1'b0, 1'b0, 100, 0, 0);
        step(3);
        stop = 1'b1;
        ovf_force = 1'b1;
        #1;
        check_output("so_carry_now", cnt.cnt_carry_in, 0);
        step(1);
        stop = 1'b0;
        ovf_force = 1'b0;
        check_output("so_busy", busy, 0);
        check_output("so_done", done, 0);
        check_output("so_irq", irq, 0);
        check_output("so_carry", cnt.cnt_carry_in, 0);
        step(2);

        // irq_clr in the expiry clock: set wins.
        apply_stimulus(1'b0, 1'b0, 100, 0, 0);
        step(3);
        ovf_force = 1'b1;
        irq_clr = 1'b1;
        exp_q.push_back(cyc + 1);
        step(1);
        ovf_force = 1'b0;
        irq_clr = 1'b0;
        check_output("clr_vs_set_irq", irq, 1);
        check_output("clr_vs_set_busy", busy, 0);
        step(1);
        check_output("clr_vs_set_done_seen", exp_q.size(), 0);

        // Overflow while idle is ignored.
        pulse_irq_clr();
        ovf_force = 1'b1;
        step(1);
        ovf_force = 1'b0;
        check_output("idle_ovf_done", done, 0);
        check_output("idle_ovf_irq", irq, 0);
        step(2);

        // period 0: expiry every prescale+1 clocks.
        apply_stimulus(1'b1, 1'b0, 0, 2, 3);
        check_output("p0_preld", cnt.cnt_preld_val, 16'hFFFF);
        step(11);
        check_output("p0_done_seen", exp_q.size(), 0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_output("p0_stop_busy", busy, 0);

`ifdef UCTRL_CAPTURE_EN
        // Capture a live value, then let the expiry overwrite it with the terminal value.
        apply_stimulus(1'b1, 1'b1, 2, 0, 2);
        step(1);
        val_force_en = 1'b1;
        val_force = 16'h1234;
        capture = 1'b1;
        step(1);
        val_force_en = 1'b0;
        capture = 1'b0;
        check_output("cap_live", cap_value, 16'h1234);
        step(2);
        check_output("cap_terminal", cap_value, 16'h0000);
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        check_output("cap_done_seen", exp_q.size(), 0);
`endif

        // Asynchronous reset on the third RUN clock aborts without any done.
        apply_stimulus(1'b1, 1'b0, 5, 0, 0);
        step(3);
        _areset = 1'b0;
        #1;
        check_reset_values("mid");
        step(3);
        _areset = 1'b1;
        step(8);
        check_output("mid_after_busy", busy, 0);
        check_output("mid_after_done", done, 0);
        check_output("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
